imem_boot_sequencer: RTL and testbench

//  Boot controller in front of the cpu external memory ports. Accepts a valid/ready

---
 rtl/cpu_boot_pkg.sv | 18 +
 rtl/imem_boot_sequencer.sv | 159 +++++++++++++++
 tb/tb_imem_boot_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_boot_pkg.sv
// Shared definitions for the instruction-memory boot sequencer.
package cpu_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ      = 3'd3,
        ST_CHECK     = 3'd4,
        ST_RUN       = 3'd5,
        ST_ERROR     = 3'd6
    } boot_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_LENGTH   = 2'b10;

endpackage

// File: rtl/imem_boot_sequencer.sv
// Boot sequencer: streams instruction words into imem through the external
// port, reads each word back for verification, then enables the cpu.
module imem_boot_sequencer
    import cpu_boot_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned CNT_W      = 10,
    parameter logic [63:0] BASE_ADDR  = 64'd0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic             halt,
    input  logic [CNT_W-1:0] word_count,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_index
);

    boot_state_e      state_q, state_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      word_q, word_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] err_index_q, err_index_d;
    logic             done_q, done_d;
    logic [63:0]      word_addr;

    // Register all state and data; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            count_q     <= '0;
            word_q      <= '0;
            err_code_q  <= ERR_NONE;
            err_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            count_q     <= count_d;
            word_q      <= word_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; done_d is raised only on transitions into RUN.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        count_d     = count_q;
        word_d      = word_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else if ({1'b0, word_count} > (CNT_W+1)'(IMEM_WORDS)) begin
                        state_d     = ST_ERROR;
                        err_code_d  = ERR_LENGTH;
                        err_index_d = '0;
                    end else begin
                        count_d = word_count;
                        index_d = '0;
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (s_valid) begin
                    word_d  = s_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_READ;
            ST_READ:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (rdata_ext != word_q) begin
                    state_d     = ST_ERROR;
                    err_code_d  = ERR_MISMATCH;
                    err_index_d = index_q;
                end else if (index_q == count_q - CNT_W'(1)) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    index_d = index_q + CNT_W'(1);
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_RUN: begin
                if (halt) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (halt) begin
                    state_d     = ST_IDLE;
                    err_code_d  = ERR_NONE;
                    err_index_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign word_addr = BASE_ADDR + {{(62-CNT_W){1'b0}}, index_q, 2'b00};

    // Output decode from registered state/data only; address and data are
    // zeroed outside memory-access states so reset leaves every output at 0.
    always_comb begin
        s_ready    = 1'b0;
        wen_ext    = 1'b0;
        ren_ext    = 1'b0;
        addr_ext   = '0;
        wdata_ext  = '0;
        cpu_enable = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            ST_WAIT_DATA: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            ST_WRITE: begin
                wen_ext   = 1'b1;
                addr_ext  = word_addr;
                wdata_ext = word_q;
                busy      = 1'b1;
            end
            ST_READ: begin
                ren_ext  = 1'b1;
                addr_ext = word_addr;
                busy     = 1'b1;
            end
            ST_CHECK: busy = 1'b1;
            ST_RUN:   cpu_enable = 1'b1;
            default: ;
        endcase
    end

    assign done      = done_q;
    assign err_code  = err_code_q;
    assign err_index = err_index_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Self-checking bench for imem_boot_sequencer: a memory model answers the
// external port, and a word-level behavioural model predicts every output.
module tb_imem_boot_sequencer;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [9:0]  word_count = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext = '0;
    logic        cpu_enable;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [9:0]  err_index;

    imem_boot_sequencer #(
        .IMEM_WORDS(512),
        .CNT_W(10),
        .BASE_ADDR(64'd0)
    ) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .halt(halt),
        .word_count(word_count), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .addr_ext(addr_ext), .wen_ext(wen_ext),
        .ren_ext(ren_ext), .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .cpu_enable(cpu_enable), .busy(busy), .done(done),
        .err_code(err_code), .err_index(err_index)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [31:0] img [512];
    logic [31:0] mem [512];
    logic [63:0] wlog [$];
    int rd_cnt = 0;
    int ptr = 0;
    int hold_idx = -1;
    int hold_left = 0;
    int corrupt_idx = -1;
    bit stream_on = 1'b1;
    bit rand_gap = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream source: advances through img[] on each accepted handshake;
    // an optional hold keeps s_valid low for a number of ready cycles.
    always @(posedge clk) begin
        if (s_valid && s_ready) ptr = ptr + 1;
        else if (s_ready && hold_left > 0 && ptr == hold_idx) hold_left = hold_left - 1;
        #1;
        s_data  = img[ptr % 512];
        s_valid = stream_on && !(ptr == hold_idx && hold_left > 0)
                  && (!rand_gap || $urandom_range(0, 3) != 0);
    end

    // Instruction memory: one-cycle read latency; a chosen word reads back with bit 0 flipped.
    always @(posedge clk) begin
        if (wen_ext) begin
            mem[addr_ext[10:2]] <= wdata_ext;
            wlog.push_back(addr_ext);
        end
        if (ren_ext) begin
            rd_cnt++;
            rdata_ext <= mem[addr_ext[10:2]] ^
                         ((int'(addr_ext[10:2]) == corrupt_idx) ? 32'h1 : 32'h0);
        end
    end

    // Behavioural model: mode 0 idle, 1 loading, 2 running, 3 error.
    // While loading, each word takes a wait slot (0) then three fixed slots (1..3).
    int m_mode = 0, m_phase = 0, m_idx = 0, m_cnt = 0, m_err = 0, m_eidx = 0;
    bit m_done = 1'b0;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_mode <= 0; m_phase <= 0; m_idx <= 0; m_cnt <= 0;
            m_err <= 0; m_eidx <= 0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            case (m_mode)
                0: if (start) begin
                    if (word_count == 0) begin
                        m_mode <= 2; m_done <= 1'b1;
                    end else if (int'(word_count) > 512) begin
                        m_mode <= 3; m_err <= 2; m_eidx <= 0;
                    end else begin
                        m_mode <= 1; m_phase <= 0; m_idx <= 0; m_cnt <= int'(word_count);
                    end
                end
                1: begin
                    if (m_phase == 0) begin
                        if (s_valid) m_phase <= 1;
                    end else if (m_phase < 3) begin
                        m_phase <= m_phase + 1;
                    end else if (m_idx == corrupt_idx) begin
                        m_mode <= 3; m_err <= 1; m_eidx <= m_idx;
                    end else if (m_idx == m_cnt - 1) begin
                        m_mode <= 2; m_done <= 1'b1;
                    end else begin
                        m_idx <= m_idx + 1; m_phase <= 0;
                    end
                end
                2: if (halt) m_mode <= 0;
                default: if (halt) begin
                    m_mode <= 0; m_err <= 0; m_eidx <= 0;
                end
            endcase
        end
    end

    function automatic logic [113:0] model_vec();
        logic        e_wen, e_ren;
        logic [63:0] e_addr;
        logic [31:0] e_wdata;
        e_wen   = (m_mode == 1 && m_phase == 1);
        e_ren   = (m_mode == 1 && m_phase == 2);
        e_addr  = (e_wen || e_ren) ? 64'(4 * m_idx) : 64'd0;
        e_wdata = e_wen ? img[m_idx] : 32'd0;
        return {(m_mode == 1 && m_phase == 0), e_wen, e_ren, e_addr, e_wdata,
                (m_mode == 2), (m_mode == 1), m_done, 2'(m_err), 10'(m_eidx)};
    endfunction

    // Every-cycle comparison of the full output set against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("outputs", 128'({s_ready, wen_ext, ren_ext, addr_ext, wdata_ext,
                                 cpu_enable, busy, done, err_code, err_index}),
                128'(model_vec()));
            if (wen_ext && ren_ext) chk("wen_ren_exclusive", 1, 0);
        end
    end

    // Start a load at cycle c0; returns at the negedge of c1.
    task automatic launch(input int cnt, input bit with_halt);
        @(negedge clk);
        ptr = 0; word_count = 10'(cnt); start = 1'b1; halt = with_halt;
        @(negedge clk);
        start = 1'b0; halt = 1'b0;
    endtask

    task automatic settle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (m_mode == 2 || m_mode == 3) begin
                ok = 1'b1;
                break;
            end
            if (m_mode == 1 && m_phase < 2) begin
                start = ($urandom_range(0, 7) == 0);
                halt  = ($urandom_range(0, 7) == 0);
            end else begin
                start = 1'b0; halt = 1'b0;
            end
        end
        start = 1'b0; halt = 1'b0;
        chk("settle_timeout", 128'(ok), 128'(1));
    endtask

    task automatic do_halt();
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
    endtask

    task automatic chk_mem(input int cnt);
        for (int i = 0; i < cnt; i++) chk("mem_image", 128'(mem[i]), 128'(img[i]));
    endtask

    initial begin
        bit ok;
        int cnt;
        bit cpu_seen;

        // Reset
        #2 arst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({s_ready, wen_ext, ren_ext, addr_ext, wdata_ext, cpu_enable,
                                   busy, done, err_code, err_index}), 128'(0));
        arst_n = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", 128'(s_ready), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));

        // Normal load of three words; start and halt together in IDLE
        img[0] = 32'h00500093; img[1] = 32'h00100113; img[2] = 32'h002081B3;
        wlog.delete();
        launch(3, 1'b1);
        repeat (12) @(negedge clk);
        chk("c13_cpu_enable", 128'(cpu_enable), 128'(1));
        chk("c13_done", 128'(done), 128'(1));
        chk("c13_model_done", 128'(m_done), 128'(1));
        @(negedge clk);
        chk("c14_done", 128'(done), 128'(0));
        chk("write_count", 128'(wlog.size()), 128'(3));
        if (wlog.size() == 3) begin
            chk("write_addr0", 128'(wlog[0]), 128'(0));
            chk("write_addr1", 128'(wlog[1]), 128'(4));
            chk("write_addr2", 128'(wlog[2]), 128'(8));
        end
        chk_mem(3);
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("halt_cpu_off", 128'(cpu_enable), 128'(0));

        // Stream gap of 5 ready cycles before word 1
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        wlog.delete(); rd_cnt = 0;
        hold_idx = 1; hold_left = 5;
        launch(3, 1'b0);
        repeat (16) @(negedge clk);
        chk("gap_c17_not_done", 128'(cpu_enable), 128'(0));
        @(negedge clk);
        chk("gap_c18_done", 128'({cpu_enable, done}), 128'(2'b11));
        chk("gap_writes", 128'(wlog.size()), 128'(3));
        chk("gap_reads", 128'(rd_cnt), 128'(3));
        chk_mem(3);
        hold_idx = -1;
        do_halt();

        // Readback mismatch on word 1
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        corrupt_idx = 1;
        cpu_seen = 1'b0;
        launch(4, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (cpu_enable) cpu_seen = 1'b1;
            @(negedge clk);
        end
        chk("mm_err_code", 128'(err_code), 128'(1));
        chk("mm_err_index", 128'(err_index), 128'(1));
        @(negedge clk);
        word_count = 10'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (cpu_enable) cpu_seen = 1'b1;
        chk("mm_start_ignored", 128'({busy, err_code}), 128'({1'b0, 2'b01}));
        chk("mm_cpu_never", 128'(cpu_seen), 128'(0));
        do_halt();
        chk("mm_cleared", 128'({err_code, err_index, busy}), 128'(0));
        corrupt_idx = -1;

        // Length edges
        launch(0, 1'b0);
        chk("cnt0_run_c1", 128'({cpu_enable, done}), 128'(2'b11));
        do_halt();
        wlog.delete(); rd_cnt = 0;
        launch(513, 1'b0);
        chk("cnt513_err_c1", 128'({err_code, err_index}), 128'({2'b10, 10'd0}));
        repeat (3) @(negedge clk);
        chk("cnt513_no_access", 128'(wlog.size() + rd_cnt), 128'(0));
        do_halt();

        // Reset during WRITE of word 2, then reload from index 0
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        launch(4, 1'b0);
        repeat (9) @(negedge clk);
        chk("abort_in_write", 128'({wen_ext, addr_ext}), 128'({1'b1, 64'd8}));
        #1 arst_n = 1'b0;
        #1 chk("abort_wen_low", 128'({wen_ext, addr_ext, busy}), 128'(0));
        @(negedge clk);
        arst_n = 1'b1;
        wlog.delete();
        launch(4, 1'b0);
        @(negedge clk);
        chk("reload_addr0", 128'({wen_ext, addr_ext}), 128'({1'b1, 64'd0}));
        settle(ok);
        chk("reload_run", 128'(cpu_enable), 128'(1));
        chk_mem(4);
        do_halt();

        // Randomized loads: gaps, stray start/halt, occasional corruption or overlength
        for (int it = 0; it < 10; it++) begin
            cnt = $urandom_range(1, 12);
            if ($urandom_range(0, 7) == 0) cnt = $urandom_range(513, 1023);
            for (int i = 0; i < 12; i++) img[i] = $urandom;
            rand_gap = $urandom_range(0, 1);
            corrupt_idx = ($urandom_range(0, 3) == 0 && cnt <= 12) ? $urandom_range(0, cnt - 1) : -1;
            launch(cnt, $urandom_range(0, 1));
            if (m_mode != 2 && m_mode != 3) settle(ok);
            if (cnt > 512) begin
                chk("rnd_len_err", 128'({err_code, err_index}), 128'({2'b10, 10'd0}));
            end else if (corrupt_idx >= 0) begin
                chk("rnd_mm_err", 128'({err_code, err_index}), 128'({2'b01, 10'(corrupt_idx)}));
                chk_mem(corrupt_idx + 1);
            end else begin
                chk("rnd_run", 128'({cpu_enable, done}), 128'(2'b11));
                chk_mem(cnt);
            end
            do_halt();
            corrupt_idx = -1;
        end
        rand_gap = 1'b0;

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
